// File: rtl/track_result_buffer_pkg.sv
// Shared field widths, bit offsets and record width for tracking-loop results.
// TRACK_BUF_TIMESTAMP_EN adds a 32-bit timestamp field at the record MSBs.
package track_result_buffer_pkg;

    localparam int DEPTH_DEF  = 8;
    localparam int ACC_W_DEF  = 16;
    localparam int W_DF_W_DEF = 16;
    localparam int DPHI_W_DEF = 32;
    localparam int TAU_W_DEF  = 17;
    localparam int TS_W       = 32;

`ifdef TRACK_BUF_TIMESTAMP_EN
    localparam int TS_EN = 1;
`else
    localparam int TS_EN = 0;
`endif

    // Offsets count up from the LSB; tau_prime sits at bit 0.
    function automatic int off_ca(input int tau);
        return tau;
    endfunction

    function automatic int off_car(input int dphi, input int tau);
        return tau + dphi;
    endfunction

    function automatic int off_wdot(input int dphi, input int tau);
        return tau + 2 * dphi;
    endfunction

    function automatic int off_wdf(input int wdf, input int dphi,
                                   input int tau);
        return tau + 2 * dphi + wdf;
    endfunction

    function automatic int off_q(input int wdf, input int dphi,
                                 input int tau);
        return tau + 2 * dphi + 2 * wdf;
    endfunction

    function automatic int off_i(input int acc, input int wdf,
                                 input int dphi, input int tau);
        return tau + 2 * dphi + 2 * wdf + acc;
    endfunction

    function automatic int off_ts(input int acc, input int wdf,
                                  input int dphi, input int tau);
        return tau + 2 * dphi + 2 * wdf + 2 * acc;
    endfunction

    function automatic int rec_w(input int acc, input int wdf,
                                 input int dphi, input int tau);
        return 2 * acc + 2 * wdf + 2 * dphi + tau + TS_EN * TS_W;
    endfunction

endpackage

// File: rtl/track_buf_fifo.sv
// First-word-fall-through FIFO with occupancy level.
// Pointers carry one extra wrap bit to tell full from empty.
module track_buf_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             data_i,
    output logic                     full_o,
    output logic                     valid_o,
    output logic [W-1:0]             data_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr_q, wptr_d;
    logic [AW:0]  rptr_q, rptr_d;
    logic         empty;
    logic         wr_en;
    logic         rd_en;

    assign empty = (wptr_q == rptr_q);
    assign full_o = (wptr_q[AW] != rptr_q[AW]) &&
                    (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rd_en = pop_i & ~empty;
    // A pop in the same cycle frees the slot the write needs.
    assign wr_en = push_i & (~full_o | rd_en);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (wr_en) wptr_d = wptr_q + 1'b1;
            if (rd_en) rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !clr_i) mem[wptr_q[AW-1:0]] <= data_i;
    end

    assign valid_o = ~empty;
    assign data_o  = mem[rptr_q[AW-1:0]];
    assign level_o = wptr_q - rptr_q;

endmodule

// File: rtl/track_result_buffer.sv
// Buffers tracking-loop update records for a downstream consumer.
// TRACK_BUF_TIMESTAMP_EN adds sample_count and a per-record timestamp.
module track_result_buffer
    import track_result_buffer_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int W_DF_W = W_DF_W_DEF,
    parameter int DPHI_W = DPHI_W_DEF,
    parameter int TAU_W  = TAU_W_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                tracking_ready,
    input  logic [ACC_W-1:0]    i_prompt,
    input  logic [ACC_W-1:0]    q_prompt,
    input  logic [W_DF_W-1:0]   w_df,
    input  logic [W_DF_W-1:0]   w_df_dot,
    input  logic [DPHI_W-1:0]   carrier_dphi,
    input  logic [DPHI_W-1:0]   ca_dphi,
    input  logic [TAU_W-1:0]    tau_prime,
`ifdef TRACK_BUF_TIMESTAMP_EN
    input  logic [31:0]         sample_count,
`endif
    input  logic                rd_ready,
    output logic                rd_valid,
    output logic [rec_w(ACC_W, W_DF_W, DPHI_W, TAU_W)-1:0] rd_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                overflow,
    output logic [15:0]         drop_count
);

    localparam int REC_W = rec_w(ACC_W, W_DF_W, DPHI_W, TAU_W);

    logic [REC_W-1:0] wr_rec;
    logic             full;
    logic             drop;
    logic             ovf_q, ovf_d;
    logic [15:0]      drops_q, drops_d;

    always_comb begin
        wr_rec = '0;
        wr_rec[0 +: TAU_W] = tau_prime;
        wr_rec[off_ca(TAU_W) +: DPHI_W] = ca_dphi;
        wr_rec[off_car(DPHI_W, TAU_W) +: DPHI_W] = carrier_dphi;
        wr_rec[off_wdot(DPHI_W, TAU_W) +: W_DF_W] = w_df_dot;
        wr_rec[off_wdf(W_DF_W, DPHI_W, TAU_W) +: W_DF_W] = w_df;
        wr_rec[off_q(W_DF_W, DPHI_W, TAU_W) +: ACC_W] = q_prompt;
        wr_rec[off_i(ACC_W, W_DF_W, DPHI_W, TAU_W) +: ACC_W] = i_prompt;
`ifdef TRACK_BUF_TIMESTAMP_EN
        wr_rec[off_ts(ACC_W, W_DF_W, DPHI_W, TAU_W) +: TS_W] = sample_count;
`endif
    end

    track_buf_fifo #(
        .W     (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .clr_i   (clear),
        .push_i  (tracking_ready),
        .pop_i   (rd_ready),
        .data_i  (wr_rec),
        .full_o  (full),
        .valid_o (rd_valid),
        .data_o  (rd_data),
        .level_o (level)
    );

    assign drop = tracking_ready & full & ~(rd_valid & rd_ready) & ~clear;

    always_comb begin
        ovf_d   = ovf_q;
        drops_d = drops_q;
        if (clear) begin
            ovf_d   = 1'b0;
            drops_d = '0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (drops_q != 16'hFFFF) drops_d = drops_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q   <= 1'b0;
            drops_q <= '0;
        end else begin
            ovf_q   <= ovf_d;
            drops_q <= drops_d;
        end
    end

    assign overflow   = ovf_q;
    assign drop_count = drops_q;

endmodule
